stream_done_monitor: RTL
========================

STREAM_DONE_MONITOR -- requirements
Module: stream_done_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 2, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of token counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port clk_en  input  1  global enable; 0 freezes all state.
REQ-006 SHALL have port flush  input  1  synchronous soft clear.
REQ-007 SHALL have port tile_en  input  1  tile enable; 0 gates both handshakes.
REQ-008 SHALL have port stream_in  input  17  upstream token; bit16=1 marks a control token.
REQ-009 SHALL have port stream_in_valid  input  1  upstream valid.
REQ-010 SHALL have port stream_in_ready  output  1  upstream ready.
REQ-011 SHALL have port stream_out  output  17  downstream token (FIFO head).
REQ-012 SHALL have port stream_out_valid  output  1  downstream valid.
REQ-013 SHALL have port stream_out_ready  input  1  downstream ready.
REQ-014 SHALL have port done  output  1  done token has left stream_out.
REQ-015 SHALL have ports data_count and stop_count  output  CNT_W each  tokens transferred out.

Function
REQ-016 SHALL classify tokens: bit16=0 data; 17'h10100 done; bit16=1 with [15:8]=8'h00 stop; any other control passes through uncounted.
REQ-017 SHALL buffer tokens in a DEPTH-entry FIFO; accept-to-stream_out_valid latency is exactly 1 cycle.
REQ-018 SHALL drive stream_in_ready = tile_en & ~full & (state in IDLE or ACTIVE); no combinational path from stream_out_ready.
REQ-019 SHALL drive stream_out_valid = tile_en & ~empty; stream_out holds the head entry stable while valid and not ready.
REQ-020 SHALL support simultaneous push and pop in one cycle at any occupancy below full; when full, push waits one cycle after a pop.
REQ-021 SHALL implement states IDLE -> ACTIVE on first accepted token; ACTIVE -> DRAIN when the done token is accepted at the input; DRAIN -> DONE when the done token transfers out.
REQ-022 SHALL go IDLE -> DRAIN directly if the first accepted token is the done token.
REQ-023 SHALL assert done only in DONE; done stays 1 until flush or rst.
REQ-024 SHALL increment data_count and stop_count on output transfer of the matching class, saturating at all-ones.
REQ-025 SHALL, on flush with clk_en=1, empty the FIFO, zero counters and return to IDLE; a token offered that cycle is dropped.
REQ-026 SHALL, when clk_en=0, hold all state; outputs reflect held state.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, empty the FIFO, zero counters, enter IDLE; stream_in_ready follows tile_en, stream_out_valid=0, done=0.
REQ-028 SHALL give rst priority over flush over clk_en; rst is honoured regardless of clk_en, including mid-stream with the FIFO full.

Configuration
REQ-029 SHALL, with STREAM_PERF_CNT_EN defined, add output cycle_count (32 bits) counting clk_en cycles while state is ACTIVE or DRAIN, frozen in DONE, cleared by rst/flush.
REQ-030 SHALL, without STREAM_PERF_CNT_EN, omit port cycle_count and its counter entirely.

Structure
REQ-031 SHALL place TOKEN_W=17, DONE_TOKEN=17'h10100, stop-prefix constant, token-class enum and state enum in package sparse_stream_pkg.
REQ-032 SHALL implement the FIFO as sub-module token_fifo (DEPTH, data width 17, push/pop/full/empty/flush).

Verification
REQ-033 SHALL cover: 3 data (0x00005,0x00007,0x00009), stop 0x10000, done 0x10100, out_ready=1 -> tokens out in order 1 cycle after accept, data_count=3, stop_count=1, done=1, input ready=0 thereafter.
REQ-034 SHALL cover: out_ready=0 for 10 cycles while streaming -> FIFO fills at 2, in_ready=0, no token lost or duplicated after release.
REQ-035 SHALL cover: flush pulse with 2 tokens buffered and counters at 1 -> next cycle valid=0, counters=0, state IDLE, in_ready=1.
REQ-036 SHALL cover: done token as first token -> done=1 one cycle after its output transfer, counters 0; with STREAM_PERF_CNT_EN, cycle_count=1 for a 1-cycle DRAIN.
REQ-037 SHALL cover: clk_en=0 for 5 cycles mid-stream and tile_en=0 for 3 cycles -> no state change, both handshakes inactive, stream resumes intact.
REQ-038 SHALL cover: CNT_W=4 with 20 data tokens -> data_count saturates at 15.

Source files
------------

// File: rtl/sparse_stream_pkg.sv
// rtl/sparse_stream_pkg.sv - token constants, token classes and monitor states
package sparse_stream_pkg;

  localparam int TOKEN_W = 17;
  localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;
  localparam logic [7:0] STOP_PREFIX = 8'h00;

  typedef enum logic [1:0] {
    TOK_DATA,
    TOK_STOP,
    TOK_DONE,
    TOK_OTHER
  } tok_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Done is tested before stop: it is a control token with a nonzero prefix.
  function automatic tok_class_e classify(input logic [TOKEN_W-1:0] tok);
    tok_class_e cls;
    if (!tok[TOKEN_W-1]) begin
      cls = TOK_DATA;
    end else if (tok == DONE_TOKEN) begin
      cls = TOK_DONE;
    end else if (tok[15:8] == STOP_PREFIX) begin
      cls = TOK_STOP;
    end else begin
      cls = TOK_OTHER;
    end
    return cls;
  endfunction

endpackage

// File: rtl/token_fifo.sv
// rtl/token_fifo.sv - DEPTH-entry token FIFO with enable, flush and sync reset
module token_fifo
  import sparse_stream_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = TOKEN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (en_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (!rst_i && en_i && !flush_i && do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/stream_done_monitor.sv
// rtl/stream_done_monitor.sv - token stream monitor with done detection; STREAM_PERF_CNT_EN adds cycle_count
module stream_done_monitor
  import sparse_stream_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               flush,
  input  logic               tile_en,
  input  logic [TOKEN_W-1:0] stream_in,
  input  logic               stream_in_valid,
  output logic               stream_in_ready,
  output logic [TOKEN_W-1:0] stream_out,
  output logic               stream_out_valid,
  input  logic               stream_out_ready,
  output logic               done,
  output logic [CNT_W-1:0]   data_count,
  output logic [CNT_W-1:0]   stop_count
`ifdef STREAM_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_count
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0] stop_cnt_q, stop_cnt_d;
  logic             fifo_full, fifo_empty;
  logic             in_fire, out_fire;
  tok_class_e       in_cls, out_cls;

  token_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TOKEN_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (clk_en),
    .flush_i     (flush),
    .push_i      (in_fire),
    .push_data_i (stream_in),
    .pop_i       (out_fire),
    .pop_data_o  (stream_out),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Ready depends only on registered state, never on stream_out_ready.
  assign stream_in_ready  = tile_en & ~fifo_full &
                            ((state_q == ST_IDLE) | (state_q == ST_ACTIVE));
  assign stream_out_valid = tile_en & ~fifo_empty;
  assign in_fire          = stream_in_valid & stream_in_ready;
  assign out_fire         = stream_out_valid & stream_out_ready;
  assign in_cls           = classify(stream_in);
  assign out_cls          = classify(stream_out);
  assign done             = (state_q == ST_DONE);
  assign data_count       = data_cnt_q;
  assign stop_count       = stop_cnt_q;

  always_comb begin
    state_d    = state_q;
    data_cnt_d = data_cnt_q;
    stop_cnt_d = stop_cnt_q;
    if (flush) begin
      state_d    = ST_IDLE;
      data_cnt_d = '0;
      stop_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE:   if (in_fire) state_d = (in_cls == TOK_DONE) ? ST_DRAIN : ST_ACTIVE;
        ST_ACTIVE: if (in_fire && in_cls == TOK_DONE) state_d = ST_DRAIN;
        ST_DRAIN:  if (out_fire && out_cls == TOK_DONE) state_d = ST_DONE;
        default:   state_d = state_q;
      endcase
      if (out_fire && out_cls == TOK_DATA && data_cnt_q != '1) data_cnt_d = data_cnt_q + 1'b1;
      if (out_fire && out_cls == TOK_STOP && stop_cnt_q != '1) stop_cnt_d = stop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_cnt_q <= '0;
      stop_cnt_q <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      data_cnt_q <= data_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

`ifdef STREAM_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  assign cycle_count = cyc_q;

  always_comb begin
    cyc_d = cyc_q;
    if (flush) begin
      cyc_d = '0;
    end else if (state_q == ST_ACTIVE || state_q == ST_DRAIN) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (clk_en) begin
      cyc_q <= cyc_d;
    end
  end
`endif

endmodule
